m_dram_port: RTL and testbench

Memory-side port placed directly downstream of the MMU: it consumes the MMU's DRAM request signals (address, write data, write/load strobes, funct3 size control) and returns read data plus a busy flag. It converts 32-bit sub-word accesses into 128-bit line transactions with byte masks on a req/ack memory interface. It holds a single-line read buffer to absorb back-to-back fetches and page-walk reads from the same line.

---
 rtl/m_dram_port_pkg.sv | 29 ++
 rtl/m_dram_lane.sv | 69 ++++++
 rtl/m_dram_port.sv | 189 ++++++++++++++++++
 tb/tb_m_dram_port.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/m_dram_port_pkg.sv
// Shared constants for the DRAM-side port of the MMU.
//
// Contents:
//   FUNCT3_*        load/store size encodings carried on w_ctrl
//   MEM_BASE_TADDR  address[31:28] value of the cacheable DRAM window
//   ST_*            port FSM state encodings
//   dram_req_t      snapshot of an accepted request, used to suppress re-issue
package m_dram_port_pkg;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;

    localparam logic [3:0] MEM_BASE_TADDR = 4'h8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MREQ = 2'd1;
    localparam logic [1:0] ST_WREQ = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [2:0]  ctrl;
    } dram_req_t;

endpackage

// File: rtl/m_dram_lane.sv
// Combinational lane logic for a 128-bit line.
//
// Ports:
//   off    in  4    byte offset within the line
//   ctrl   in  3    funct3 size/sign control
//   line   in  128  line to extract from
//   wdata  in  32   LSB-aligned store data
//   rdata  out 32   extracted byte/half/word, sign- or zero-extended
//   wmask  out 16   byte enables for a store at off
//   wline  out 128  store data shifted into its lane, zeros elsewhere
//   bmask  out 128  wmask expanded to one bit per data bit (for merges)
module m_dram_lane
    import m_dram_port_pkg::*;
(
    input  logic [3:0]   off,
    input  logic [2:0]   ctrl,
    input  logic [127:0] line,
    input  logic [31:0]  wdata,
    output logic [31:0]  rdata,
    output logic [15:0]  wmask,
    output logic [127:0] wline,
    output logic [127:0] bmask
);

    logic [159:0] padded;
    logic [31:0]  sel_word;
    logic [15:0]  size_mask;
    logic [31:0]  sized_data;

    // Padding keeps a misaligned half/word select in range; the extra
    // bytes read as zero, which is acceptable since such data is undefined.
    assign padded   = {32'b0, line};
    assign sel_word = padded[{off, 3'b000} +: 32];

    always_comb begin
        rdata      = sel_word;
        size_mask  = 16'h000F;
        sized_data = wdata;
        case (ctrl[1:0])
            2'b00: begin
                rdata      = (ctrl[2]) ? {24'b0, sel_word[7:0]}
                                       : {{24{sel_word[7]}}, sel_word[7:0]};
                size_mask  = 16'h0001;
                sized_data = {24'b0, wdata[7:0]};
            end
            2'b01: begin
                rdata      = (ctrl[2]) ? {16'b0, sel_word[15:0]}
                                       : {{16{sel_word[15]}}, sel_word[15:0]};
                size_mask  = 16'h0003;
                sized_data = {16'b0, wdata[15:0]};
            end
            default: begin
                rdata      = sel_word;
                size_mask  = 16'h000F;
                sized_data = wdata;
            end
        endcase
    end

    assign wmask = size_mask << off;
    assign wline = {96'b0, sized_data} << {off, 3'b000};

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_bmask
            assign bmask[gi*8 +: 8] = {8{wmask[gi]}};
        end
    endgenerate

endmodule

// File: rtl/m_dram_port.sv
// DRAM-side port downstream of the MMU: turns 32-bit sub-word loads/stores
// into 128-bit line transactions on a req/ack interface, with a one-line
// read buffer for the cacheable window.
//
// Ports:
//   CLK, RST_X          clock, asynchronous active-low reset
//   w_addr/w_wdata      request byte address and LSB-aligned store data
//   w_we/w_le/w_ctrl    store strobe, load strobe, funct3 size control
//   w_odata             registered load result
//   w_busy              high while a request is being handled
//   o_req/o_we/o_addr   downstream request, write flag, line index
//   o_wdata/o_wmask     downstream store line and byte enables
//   i_ack/i_rdata       downstream completion and read line
module m_dram_port
    import m_dram_port_pkg::*;
#(
    parameter int LINE_W = 128,
    parameter int ADDR_W = 27
) (
    input  logic              CLK,
    input  logic              RST_X,
    input  logic [31:0]       w_addr,
    input  logic [31:0]       w_wdata,
    input  logic              w_we,
    input  logic              w_le,
    input  logic [2:0]        w_ctrl,
    output logic [31:0]       w_odata,
    output logic              w_busy,
    output logic              o_req,
    output logic              o_we,
    output logic [ADDR_W-5:0] o_addr,
    output logic [LINE_W-1:0] o_wdata,
    output logic [15:0]       o_wmask,
    input  logic              i_ack,
    input  logic [LINE_W-1:0] i_rdata
);

    logic [1:0]        state_reg;
    logic              strobe_prev_reg;
    dram_req_t         last_req_reg;
    logic [3:0]        req_off_reg;
    logic [2:0]        req_ctrl_reg;
    logic              req_cache_reg;
    logic              o_req_reg;
    logic              o_we_reg;
    logic [ADDR_W-5:0] o_addr_reg;
    logic [127:0]      o_wdata_reg;
    logic [15:0]       o_wmask_reg;
    logic [31:0]       odata_reg;
    logic [127:0]      buf_data_reg;
    logic [ADDR_W-5:0] buf_tag_reg;
    logic              buf_valid_reg;

    logic              strobe;
    dram_req_t         cur_req;
    logic              accept;
    logic [ADDR_W-5:0] line_idx;
    logic              cacheable;
    logic              buf_match;

    logic [3:0]        lane_off;
    logic [2:0]        lane_ctrl;
    logic [127:0]      lane_line;
    logic [31:0]       lane_rdata;
    logic [15:0]       lane_wmask;
    logic [127:0]      lane_wline;
    logic [127:0]      lane_bmask;

    assign strobe    = w_le | w_we;
    assign cur_req   = '{addr: w_addr, we: w_we, ctrl: w_ctrl};
    // A strobe held high with an unchanged request must not be re-issued.
    assign accept    = (state_reg == ST_IDLE) && strobe &&
                       (!strobe_prev_reg || (cur_req != last_req_reg));
    assign line_idx  = w_addr[ADDR_W-1:4];
    assign cacheable = (w_addr[31:28] == MEM_BASE_TADDR);
    // Cacheability is part of the match: the tag alone aliases lines from
    // outside the DRAM window because the upper address bits are dropped.
    assign buf_match = buf_valid_reg && (buf_tag_reg == line_idx) && cacheable;

    // One lane unit is shared: while a read miss is outstanding it extracts
    // from the returning line using the saved offset/size; otherwise it
    // serves buffer hits, store masks and the buffer merge.
    always_comb begin
        lane_off  = w_addr[3:0];
        lane_ctrl = w_ctrl;
        lane_line = buf_data_reg;
        if (state_reg == ST_MREQ) begin
            lane_off  = req_off_reg;
            lane_ctrl = req_ctrl_reg;
            lane_line = i_rdata;
        end
    end

    m_dram_lane u_lane (
        .off   (lane_off),
        .ctrl  (lane_ctrl),
        .line  (lane_line),
        .wdata (w_wdata),
        .rdata (lane_rdata),
        .wmask (lane_wmask),
        .wline (lane_wline),
        .bmask (lane_bmask)
    );

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_reg       <= ST_IDLE;
            strobe_prev_reg <= 1'b0;
            last_req_reg    <= '0;
            req_off_reg     <= '0;
            req_ctrl_reg    <= '0;
            req_cache_reg   <= 1'b0;
            o_req_reg       <= 1'b0;
            o_we_reg        <= 1'b0;
            o_addr_reg      <= '0;
            o_wdata_reg     <= '0;
            o_wmask_reg     <= '0;
            odata_reg       <= '0;
            buf_data_reg    <= '0;
            buf_tag_reg     <= '0;
            buf_valid_reg   <= 1'b0;
        end else begin
            strobe_prev_reg <= strobe;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        last_req_reg  <= cur_req;
                        req_off_reg   <= w_addr[3:0];
                        req_ctrl_reg  <= w_ctrl;
                        req_cache_reg <= cacheable;
                        if (w_we) begin
                            state_reg   <= ST_WREQ;
                            o_req_reg   <= 1'b1;
                            o_we_reg    <= 1'b1;
                            o_addr_reg  <= line_idx;
                            o_wdata_reg <= lane_wline;
                            o_wmask_reg <= lane_wmask;
                            // Keep the buffered copy coherent with the store.
                            if (buf_match) begin
                                buf_data_reg <= (buf_data_reg & ~lane_bmask) |
                                                (lane_wline & lane_bmask);
                            end
                        end else if (buf_match) begin
                            state_reg <= ST_RESP;
                            odata_reg <= lane_rdata;
                        end else begin
                            state_reg   <= ST_MREQ;
                            o_req_reg   <= 1'b1;
                            o_we_reg    <= 1'b0;
                            o_addr_reg  <= line_idx;
                            o_wdata_reg <= '0;
                            o_wmask_reg <= '0;
                        end
                    end
                end
                ST_MREQ: begin
                    if (i_ack) begin
                        state_reg <= ST_RESP;
                        o_req_reg <= 1'b0;
                        odata_reg <= lane_rdata;
                        if (req_cache_reg) begin
                            buf_data_reg  <= i_rdata;
                            buf_tag_reg   <= o_addr_reg;
                            buf_valid_reg <= 1'b1;
                        end
                    end
                end
                ST_WREQ: begin
                    if (i_ack) begin
                        state_reg <= ST_RESP;
                        o_req_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_busy  = (state_reg != ST_IDLE);
    assign w_odata = odata_reg;
    assign o_req   = o_req_reg;
    assign o_we    = o_we_reg;
    assign o_addr  = o_addr_reg;
    assign o_wdata = o_wdata_reg;
    assign o_wmask = o_wmask_reg;

endmodule

// File: tb/tb_m_dram_port.sv
// Directed bench for m_dram_port: miss/hit/store-merge/hold/non-cacheable
// and reset-during-miss sequences with hand-computed expectations.
module tb_m_dram_port;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;

    localparam logic [127:0] LINE1 = 128'h44444444_33333333_DEADBEEF_11111111;
    localparam logic [127:0] LINE2 = 128'h0BADC0DE_76543210_01234567_CAFEF00D;
    localparam logic [127:0] LINE3 = 128'hA0A0A0A0_B0B0B0B0_55667788_C0C0C0C0;

    logic          CLK = 1'b0;
    logic          RST_X = 1'b0;
    logic [31:0]   w_addr = '0;
    logic [31:0]   w_wdata = '0;
    logic          w_we = 1'b0;
    logic          w_le = 1'b0;
    logic [2:0]    w_ctrl = '0;
    logic [31:0]   w_odata;
    logic          w_busy;
    logic          o_req;
    logic          o_we;
    logic [22:0]   o_addr;
    logic [127:0]  o_wdata;
    logic [15:0]   o_wmask;
    logic          i_ack = 1'b0;
    logic [127:0]  i_rdata = '0;

    int tests_run = 0;
    int tests_failed = 0;
    int nreq;
    logic [127:0] exp_line;

    m_dram_port dut (
        .CLK     (CLK),
        .RST_X   (RST_X),
        .w_addr  (w_addr),
        .w_wdata (w_wdata),
        .w_we    (w_we),
        .w_le    (w_le),
        .w_ctrl  (w_ctrl),
        .w_odata (w_odata),
        .w_busy  (w_busy),
        .o_req   (o_req),
        .o_we    (o_we),
        .o_addr  (o_addr),
        .o_wdata (o_wdata),
        .o_wmask (o_wmask),
        .i_ack   (i_ack),
        .i_rdata (i_rdata)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic we, input logic le, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] ctrl);
        w_we    = we;
        w_le    = le;
        w_addr  = addr;
        w_wdata = wdata;
        w_ctrl  = ctrl;
        $display("[TB] txn we=%0b le=%0b addr=%08h wdata=%08h ctrl=%03b", we, le, addr, wdata, ctrl);
    endtask

    // Memory that acks every request in its first cycle; counts requests.
    task automatic run_mem(input int n, input logic [127:0] line, output int reqs);
        reqs = 0;
        repeat (n) begin
            i_ack   = o_req;
            i_rdata = o_req ? line : '0;
            if (o_req) reqs++;
            tick();
        end
        i_ack   = 1'b0;
        i_rdata = '0;
    endtask

    initial begin
        // Reset state
        tick(); tick();
        check("rst_busy",  w_busy,  0);
        check("rst_req",   o_req,   0);
        check("rst_we",    o_we,    0);
        check("rst_addr",  o_addr,  0);
        check("rst_wdata", o_wdata, 0);
        check("rst_wmask", o_wmask, 0);
        check("rst_odata", w_odata, 0);
        RST_X = 1'b1;
        tick();

        // LW miss, ack three cycles after o_req rises
        drive(0, 1, 32'h80001004, 0, LW);
        tick();                                   // T+1
        check("lw_busy_t1", w_busy, 1);
        check("lw_req_t1",  o_req,  1);
        check("lw_we_t1",   o_we,   0);
        check("lw_addr",    o_addr, 23'h0000100);
        check("lw_wmask",   o_wmask, 0);
        tick();                                   // T+2
        check("lw_busy_t2", w_busy, 1);
        check("lw_req_t2",  o_req,  1);
        tick();                                   // T+3
        check("lw_busy_t3", w_busy, 1);
        check("lw_req_t3",  o_req,  1);
        tick();                                   // A
        check("lw_busy_a",  w_busy, 1);
        i_ack = 1'b1; i_rdata = LINE1;
        tick();                                   // A+1
        i_ack = 1'b0; i_rdata = '0;
        check("lw_busy_a1", w_busy, 1);
        check("lw_req_a1",  o_req,  0);
        tick();                                   // A+2
        check("lw_busy_a2", w_busy, 0);
        check("lw_odata",   w_odata, 32'hDEADBEEF);
        tick(); tick();                           // strobe still held
        check("hold_noreq",  o_req,  0);
        check("hold_nobusy", w_busy, 0);
        drive(0, 0, 32'h80001004, 0, LW);
        tick();

        // SB 0x9C to byte 7 of the buffered line
        drive(1, 0, 32'h80001007, 32'h0000009C, LB);
        tick();
        exp_line = 128'h9C << 56;
        check("sb_req",   o_req,   1);
        check("sb_we",    o_we,    1);
        check("sb_addr",  o_addr,  23'h0000100);
        check("sb_wmask", o_wmask, 16'h0080);
        check("sb_wdata", o_wdata, exp_line);
        i_ack = 1'b1;
        tick();
        i_ack = 1'b0;
        check("sb_req_resp", o_req,   0);
        check("sb_busy",     w_busy,  1);
        check("sb_odata",    w_odata, 32'hDEADBEEF);
        tick();
        check("sb_idle", w_busy, 0);
        drive(0, 0, 32'h80001007, 0, LB);
        tick();

        // LB then LBU hitting the buffer
        drive(0, 1, 32'h80001007, 0, LB);
        tick();
        check("lb_noreq", o_req,  0);
        check("lb_busy",  w_busy, 1);
        tick();
        check("lb_odata", w_odata, 32'hFFFFFF9C);
        check("lb_idle",  w_busy,  0);
        drive(0, 1, 32'h80001007, 0, LBU);
        tick();
        check("lbu_noreq", o_req, 0);
        tick();
        check("lbu_odata", w_odata, 32'h0000009C);
        drive(0, 0, 32'h80001007, 0, LBU);
        tick();

        // SH 0x1234 to 0x80001006, then LW hit returns merged word
        drive(1, 0, 32'h80001006, 32'h00001234, LH);
        tick();
        exp_line = 128'h1234 << 48;
        check("sh_wmask", o_wmask, 16'h00C0);
        check("sh_wdata", o_wdata, exp_line);
        tick();
        i_ack = 1'b1;
        tick();
        i_ack = 1'b0;
        tick();
        drive(0, 0, 32'h80001006, 0, LH);
        tick();
        drive(0, 1, 32'h80001004, 0, LW);
        tick();
        check("merge_noreq", o_req, 0);
        tick();
        check("merge_odata", w_odata, 32'h1234BEEF);
        drive(0, 0, 32'h80001004, 0, LW);
        tick();

        // Held load issues once; address change mid-hold issues again
        drive(0, 1, 32'h80001010, 0, LW);
        run_mem(12, LINE2, nreq);
        check("hold_reqs",  nreq,    1);
        check("hold_odata", w_odata, 32'hCAFEF00D);
        drive(0, 1, 32'h80001020, 0, LW);
        run_mem(6, LINE2, nreq);
        check("hold_change_reqs", nreq,    1);
        check("hold_change_odata", w_odata, 32'hCAFEF00D);
        drive(0, 0, 32'h80001020, 0, LW);
        tick();

        // Non-cacheable loads aliasing the buffered line index
        drive(0, 1, 32'h90001024, 0, LW);
        run_mem(6, LINE3, nreq);
        check("nc1_reqs",  nreq,    1);
        check("nc1_odata", w_odata, 32'h55667788);
        drive(0, 0, 32'h90001024, 0, LW);
        tick();
        drive(0, 1, 32'h90001024, 0, LW);
        run_mem(6, LINE3, nreq);
        check("nc2_reqs", nreq, 1);
        drive(0, 0, 32'h90001024, 0, LW);
        tick();
        drive(0, 1, 32'h80001020, 0, LW);
        run_mem(6, LINE3, nreq);
        check("nc_buf_hit_reqs", nreq,    0);
        check("nc_buf_odata",    w_odata, 32'hCAFEF00D);
        drive(0, 0, 32'h80001020, 0, LW);
        tick();

        // Reset during an outstanding miss; late ack is ignored
        drive(0, 1, 32'h80001004, 0, LW);
        tick();
        check("rm_req", o_req, 1);
        #2 RST_X = 1'b0;
        #1;
        check("rm_busy",  w_busy,  0);
        check("rm_oreq",  o_req,   0);
        check("rm_we",    o_we,    0);
        check("rm_addr",  o_addr,  0);
        check("rm_wdata", o_wdata, 0);
        check("rm_wmask", o_wmask, 0);
        check("rm_odata", w_odata, 0);
        drive(0, 0, 32'h0, 0, LB);
        tick();
        RST_X = 1'b1;
        i_ack = 1'b1; i_rdata = LINE3;
        tick();
        i_ack = 1'b0; i_rdata = '0;
        check("rm_ack_busy",  w_busy,  0);
        check("rm_ack_req",   o_req,   0);
        check("rm_ack_odata", w_odata, 0);
        drive(0, 1, 32'h80001020, 0, LW);
        run_mem(6, LINE2, nreq);
        check("rm_refetch_reqs",  nreq,    1);
        check("rm_refetch_odata", w_odata, 32'hCAFEF00D);
        drive(0, 0, 32'h80001020, 0, LW);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
